// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - register-mapped match timer with one-shot/periodic modes and level interrupt
// Registers: CTRL {IE,PERIODIC,EN}, MATCH, COUNT (live), STATUS {PEND}; 1-cycle registered reads.
module timer_ctrl #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   addr,
   input  logic         we,
   input  logic [N-1:0] wdata,
   input  logic         re,
   output logic [N-1:0] rdata,
   output logic         irq,
   output logic [1:0]   state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_MATCH  = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   logic [1:0]   r_state;
   logic [1:0]   w_state_nxt;
   logic         r_en;
   logic         r_periodic;
   logic         r_ie;
   logic [N-1:0] r_match;
   logic [N-1:0] r_count;
   logic         r_pend;
   logic [N-1:0] r_rdata;

   logic w_ctrl_wr;
   logic w_match_wr;
   logic w_count_wr;
   logic w_status_wr;
   logic w_hit;
   logic w_expire;

   assign w_ctrl_wr   = we && (addr == A_CTRL);
   assign w_match_wr  = we && (addr == A_MATCH);
   assign w_count_wr  = we && (addr == A_COUNT);
   assign w_status_wr = we && (addr == A_STATUS);
   assign w_hit       = (r_count == r_match);

   // Any CTRL or COUNT write in RUN takes priority over the compare for that cycle.
   assign w_expire = (r_state == S_RUN) && !w_ctrl_wr && !w_count_wr && w_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_ctrl_wr && wdata[0]) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_ctrl_wr) begin
               w_state_nxt = wdata[0] ? S_RUN : S_IDLE;
            end else if (w_expire && !r_periodic) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (w_ctrl_wr) begin
               w_state_nxt = wdata[0] ? S_RUN : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      state = r_state;
      irq   = r_pend & r_ie;
   end

   // A CTRL write with EN=1 (re)starts from zero in every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_ctrl_wr && wdata[0]) begin
         r_count <= '0;
      end else if ((r_state == S_RUN) && !w_ctrl_wr) begin
         if (w_count_wr) begin
            r_count <= wdata;
         end else if (w_hit) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_en       <= 1'b0;
         r_periodic <= 1'b0;
         r_ie       <= 1'b0;
      end else if (w_ctrl_wr) begin
         r_en       <= wdata[0];
         r_periodic <= wdata[1];
         r_ie       <= wdata[2];
      end else if (w_expire && !r_periodic) begin
         r_en <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_match <= '0;
      end else if (w_match_wr) begin
         r_match <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend <= 1'b0;
      end else if (w_expire) begin
         r_pend <= 1'b1;
      end else if (w_status_wr && wdata[0]) begin
         r_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (re) begin
         case (addr)
            A_CTRL:   r_rdata <= {{(N-3){1'b0}}, r_ie, r_periodic, r_en};
            A_MATCH:  r_rdata <= r_match;
            A_COUNT:  r_rdata <= r_count;
            A_STATUS: r_rdata <= {{(N-1){1'b0}}, r_pend};
            default:  r_rdata <= '0;
         endcase
      end
   end

   assign rdata = r_rdata;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl
module tb_timer_ctrl;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   addr;
   logic         we;
   logic [N-1:0] wdata;
   logic         re;
   logic [N-1:0] rdata;
   logic         irq;
   logic [1:0]   state;

   int n_vec = 0;
   int n_err = 0;

   logic [N-1:0] exp_q[$];
   string        tag_q[$];
   logic         rd_seen = 1'b0;

   timer_ctrl #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .re    (re),
      .rdata (rdata),
      .irq   (irq),
      .state (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Read data appears one edge after re; compare it on the following falling edge.
   always @(posedge clk) rd_seen <= re;

   always @(negedge clk) begin
      if (rd_seen) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            chk(tag_q.pop_front(), rdata, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [N-1:0] d);
      addr = a; wdata = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [N-1:0] e, input string tag);
      addr = a; re = 1'b1;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      tick();
      re = 1'b0;
   endtask

   task automatic wrrd(input logic [1:0] a, input logic [N-1:0] d, input logic [N-1:0] e, input string tag);
      addr = a; wdata = d; we = 1'b1; re = 1'b1;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      tick();
      we = 1'b0; re = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; we = 1'b0; re = 1'b0; addr = 2'd0; wdata = '0;
      tick();
      tick();
      chk("rst_state", N'(state), 0);
      chk("rst_irq", N'(irq), 0);
      chk("rst_rdata", rdata, 0);
      reset = 1'b0;
      rd(2'd0, 0, "rst_ctrl");
      rd(2'd1, 0, "rst_match");
      rd(2'd2, 0, "rst_count");
      rd(2'd3, 0, "rst_status");

      // periodic, MATCH=3: count 0,1,2,3,0
      wr(2'd1, 3);
      wr(2'd0, 3);
      for (int i = 0; i < 5; i++) rd(2'd2, N'(i % 4), "periodic_count");
      chk("periodic_state", N'(state), 1);
      chk("irq_masked", N'(irq), 0);
      rd(2'd3, 1, "periodic_pend");
      wr(2'd3, 1);
      rd(2'd3, 0, "pend_clr");
      do_reset();

      // one-shot with IE, MATCH=2
      wr(2'd1, 2);
      wr(2'd0, 5);
      chk("oneshot_run", N'(state), 1);
      tick();
      tick();
      chk("oneshot_irq_early", N'(irq), 0);
      tick();
      chk("oneshot_irq", N'(irq), 1);
      chk("oneshot_done", N'(state), 2);
      rd(2'd0, 4, "oneshot_ctrl");
      rd(2'd2, 0, "oneshot_count");
      wr(2'd3, 1);
      chk("irq_clr", N'(irq), 0);
      chk("done_hold", N'(state), 2);
      do_reset();

      // STATUS clear coincident with expiry
      wr(2'd1, 1);
      wr(2'd0, 3);
      tick();
      tick();
      tick();
      wr(2'd3, 1);
      rd(2'd3, 1, "pend_set_wins");
      do_reset();

      // COUNT load, MATCH change below count, wrap through all-ones
      wr(2'd1, 10);
      wr(2'd0, 7);
      tick();
      wr(2'd2, 8);
      tick();
      tick();
      chk("load_irq_early", N'(irq), 0);
      tick();
      chk("load_expiry", N'(irq), 1);
      wr(2'd3, 1);
      for (int i = 0; i < 6; i++) tick();
      wr(2'd1, 5);
      tick();
      tick();
      chk("no_match_past", N'(irq), 0);
      rd(2'd2, 10, "count_past");
      wr(2'd2, 32'hFFFF_FFFE);
      rd(2'd2, 32'hFFFF_FFFE, "wrap_a");
      rd(2'd2, 32'hFFFF_FFFF, "wrap_b");
      rd(2'd2, 0, "wrap_c");
      for (int i = 0; i < 4; i++) tick();
      chk("wrap_irq_early", N'(irq), 0);
      tick();
      chk("wrap_expiry", N'(irq), 1);
      chk("wrap_state", N'(state), 1);
      rd(2'd0, 7, "ctrl_rd");

      // reset mid-RUN with PEND set
      reset = 1'b1;
      tick();
      chk("midrun_state", N'(state), 0);
      chk("midrun_irq", N'(irq), 0);
      chk("midrun_rdata", rdata, 0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      rd(2'd3, 0, "post_rst_pend");
      rd(2'd2, 0, "post_rst_count");
      rd(2'd0, 0, "post_rst_ctrl");

      // MATCH=0 expires every cycle
      wr(2'd0, 3);
      wr(2'd3, 1);
      rd(2'd3, 1, "m0_pend");
      rd(2'd2, 0, "m0_count");
      wr(2'd0, 0);
      chk("m0_stop", N'(state), 0);
      do_reset();

      // CTRL reserved bits, read/write collision, freeze on EN=0
      wr(2'd0, 32'hFFFF_FFF8);
      rd(2'd0, 0, "ctrl_upper");
      chk("ctrl_upper_state", N'(state), 0);
      wr(2'd1, 100);
      wrrd(2'd1, 50, 100, "rw_same");
      rd(2'd1, 50, "match_new");
      wr(2'd0, 1);
      for (int i = 0; i < 4; i++) tick();
      wr(2'd0, 0);
      for (int i = 0; i < 3; i++) tick();
      rd(2'd2, 4, "frozen");
      rd(2'd3, 0, "no_pend");
      chk("frozen_state", N'(state), 0);

      tick();
      chk("sb_drain", N'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter N, default 32, width of count, match and data bus.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  2  register select: 0 CTRL, 1 MATCH, 2 COUNT, 3 STATUS.
REQ-005 we  input  1  write strobe; wdata captured at the clock edge where we=1.
REQ-006 wdata  input  N  write data.
REQ-007 re  input  1  read strobe.
REQ-008 rdata  output  N  registered read data.
REQ-009 irq  output  1  interrupt request, level.
REQ-010 state  output  2  current FSM state, for debug: 0 IDLE, 1 RUN, 2 DONE.

Function
REQ-011 CTRL bits: [0] EN, [1] PERIODIC, [2] IE; bits [N-1:3] read 0, writes ignored.
REQ-012 STATUS bit [0] PEND; writing 1 to bit 0 clears PEND; writing 0 has no effect; other bits read 0.
REQ-013 FSM IDLE: count holds; on a CTRL write with EN=1, count <= 0 and next state is RUN.
REQ-014 FSM RUN: each cycle, if count == MATCH then count <= 0 and PEND <= 1 (expiry); otherwise count <= count + 1.
REQ-015 Expiry period is MATCH+1 cycles; MATCH=0 expires every cycle in RUN.
REQ-016 On expiry with PERIODIC=1: stay in RUN.
REQ-017 On expiry with PERIODIC=0: go to DONE, clear EN, count holds 0.
REQ-018 DONE: count holds; a CTRL write with EN=1 restarts as in REQ-013; a CTRL write with EN=0 goes to IDLE.
REQ-019 CTRL write with EN=0 while in RUN: go to IDLE, count holds its current value; no expiry in that cycle.
REQ-020 COUNT write while in RUN: written value loaded, overrides increment and wrap; compare not evaluated that cycle.
REQ-021 MATCH write: new value used for the compare from the following cycle.
REQ-022 Count increment wraps modulo 2^N; if count > MATCH, the timer wraps through 2^N-1 to 0 before matching.
REQ-023 PEND set by expiry and cleared by STATUS write in the same cycle: set wins, PEND=1.
REQ-024 irq = PEND & IE, derived from registered state only; IE=0 masks irq but PEND still sets.
REQ-025 Read latency 1 cycle: rdata updates on the edge where re=1, reflecting register values before that edge's writes; rdata holds when re=0.
REQ-026 Simultaneous we and re to the same address: rdata returns the old value.
REQ-027 COUNT reads return the live counter; STATUS reads return PEND in bit 0; CTRL reads reflect EN after hardware clear.

Reset
REQ-028 reset=1 at a clock edge forces state IDLE, CTRL=0, MATCH=0, count=0, PEND=0, rdata=0, irq=0.
REQ-029 Reset overrides any simultaneous write or expiry, including mid-RUN.

Verification
REQ-030 MATCH=3, CTRL=0b011 (EN, periodic) -> PEND set every 4 cycles; count sequence 0,1,2,3,0.
REQ-031 MATCH=2, CTRL=0b101 (EN, IE, one-shot) -> irq=1 three cycles after write; state DONE; CTRL reads 0b100; count stays 0.
REQ-032 PEND=1, STATUS write 1 on the same edge as expiry -> PEND remains 1; STATUS write 1 with no expiry -> PEND=0, irq=0 next cycle.
REQ-033 RUN with MATCH=10, write COUNT=8 -> expiry 3 cycles later; write MATCH=5 while count=7 -> wrap through 2^N-1 before expiry.
REQ-034 Reset asserted mid-RUN with PEND=1 -> next cycle all outputs 0 and state IDLE; no expiry until EN is rewritten.
REQ-035 MATCH=0, EN periodic -> PEND set every cycle; CTRL write EN=0 -> state IDLE, count frozen.
